// File: rtl/axil_bus_pkg.sv
// Shared types, default memory map and address decode
// for the AXI4-Lite 1-master/2-slave decoder.
package axil_bus_pkg;

  typedef enum logic [1:0] {
    SEL_SRAM,
    SEL_AES,
    SEL_ERR
  } sel_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rstate_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_SRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_SRAM_SIZE = 32'h0000_0200;
  localparam logic [31:0] DEF_AES_BASE  = 32'h0000_0300;
  localparam logic [31:0] DEF_AES_SIZE  = 32'h0000_0100;

  // 33-bit compare so a window ending at 4 GiB does not wrap
  function automatic logic hit(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] size
  );
    logic [32:0] lim;
    lim = {1'b0, base} + {1'b0, size};
    return ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} < lim);
  endfunction

  function automatic sel_t decode(
    input logic [31:0] addr,
    input logic [31:0] sram_base,
    input logic [31:0] sram_size,
    input logic [31:0] aes_base,
    input logic [31:0] aes_size
  );
    if (hit(addr, sram_base, sram_size))
      return SEL_SRAM;
    if (hit(addr, aes_base, aes_size))
      return SEL_AES;
    return SEL_ERR;
  endfunction

endpackage

// File: rtl/axil_decerr_slave.sv
// Internal responder for unmapped addresses: accepts
// immediately, answers DECERR, counts error responses.
module axil_decerr_slave
  import axil_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        aw_valid_i,
  input  logic        w_valid_i,
  input  logic        b_active_i,
  input  logic        b_ready_i,
  input  logic        ar_valid_i,
  input  logic        r_active_i,
  input  logic        r_ready_i,
  output logic        aw_ready_o,
  output logic        w_ready_o,
  output logic        b_valid_o,
  output logic [1:0]  b_resp_o,
  output logic        ar_ready_o,
  output logic        r_valid_o,
  output logic [31:0] r_data_o,
  output logic [1:0]  r_resp_o,
  output logic [7:0]  cnt_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [1:0] inc;
  logic [8:0] sum;

  assign aw_ready_o = aw_valid_i;
  assign w_ready_o  = w_valid_i;
  assign ar_ready_o = ar_valid_i;

  assign b_valid_o = b_active_i;
  assign b_resp_o  = b_active_i ? RESP_DECERR : RESP_OKAY;
  assign r_valid_o = r_active_i;
  assign r_resp_o  = r_active_i ? RESP_DECERR : RESP_OKAY;
  assign r_data_o  = '0;

  // a B and an R error handshake may land together
  assign inc = {1'b0, b_valid_o & b_ready_i}
             + {1'b0, r_valid_o & r_ready_i};
  assign sum = {1'b0, cnt_q} + {7'b0, inc};

  always_comb begin
    cnt_d = sum[7:0];
    if (sum[8])
      cnt_d = 8'hFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/axil_bus_decoder.sv
// Registered AXI4-Lite decoder: picorv32 master to SRAM (s0)
// and AES (s1); routing is latched per transaction.
module axil_bus_decoder
  import axil_bus_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE = DEF_SRAM_BASE,
  parameter logic [31:0] SRAM_SIZE = DEF_SRAM_SIZE,
  parameter logic [31:0] AES_BASE  = DEF_AES_BASE,
  parameter logic [31:0] AES_SIZE  = DEF_AES_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_awaddr,
  input  logic [2:0]  m_awprot,
  input  logic        m_awvalid,
  output logic        m_awready,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  input  logic        m_wvalid,
  output logic        m_wready,
  output logic        m_bvalid,
  output logic [1:0]  m_bresp,
  input  logic        m_bready,
  input  logic [31:0] m_araddr,
  input  logic [2:0]  m_arprot,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic        m_rvalid,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  input  logic        m_rready,
  output logic [31:0] s0_awaddr,
  output logic [2:0]  s0_awprot,
  output logic        s0_awvalid,
  input  logic        s0_awready,
  output logic [31:0] s0_wdata,
  output logic [3:0]  s0_wstrb,
  output logic        s0_wvalid,
  input  logic        s0_wready,
  input  logic        s0_bvalid,
  input  logic [1:0]  s0_bresp,
  output logic        s0_bready,
  output logic [31:0] s0_araddr,
  output logic [2:0]  s0_arprot,
  output logic        s0_arvalid,
  input  logic        s0_arready,
  input  logic        s0_rvalid,
  input  logic [31:0] s0_rdata,
  input  logic [1:0]  s0_rresp,
  output logic        s0_rready,
  output logic [31:0] s1_awaddr,
  output logic [2:0]  s1_awprot,
  output logic        s1_awvalid,
  input  logic        s1_awready,
  output logic [31:0] s1_wdata,
  output logic [3:0]  s1_wstrb,
  output logic        s1_wvalid,
  input  logic        s1_wready,
  input  logic        s1_bvalid,
  input  logic [1:0]  s1_bresp,
  output logic        s1_bready,
  output logic [31:0] s1_araddr,
  output logic [2:0]  s1_arprot,
  output logic        s1_arvalid,
  input  logic        s1_arready,
  input  logic        s1_rvalid,
  input  logic [31:0] s1_rdata,
  input  logic [1:0]  s1_rresp,
  output logic        s1_rready,
  output logic        wr_busy,
  output logic        rd_busy,
  output logic [7:0]  decerr_cnt
);

  wstate_t wstate_q, wstate_d;
  rstate_t rstate_q, rstate_d;
  sel_t    wsel_q, wsel_d;
  sel_t    rsel_q, rsel_d;
  logic    aw_done_q, aw_done_d;
  logic    w_done_q, w_done_d;

  logic        aw_g, w_g;
  logic        aw_rdy, w_rdy;
  logic        e_awvalid, e_wvalid, e_arvalid;
  logic        e_bactive, e_ractive;
  logic        e_awready, e_wready, e_arready;
  logic        e_bvalid, e_rvalid;
  logic [1:0]  e_bresp, e_rresp;
  logic [31:0] e_rdata;

  assign s0_awaddr = m_awaddr;
  assign s0_awprot = m_awprot;
  assign s0_wdata  = m_wdata;
  assign s0_wstrb  = m_wstrb;
  assign s0_araddr = m_araddr;
  assign s0_arprot = m_arprot;
  assign s1_awaddr = m_awaddr;
  assign s1_awprot = m_awprot;
  assign s1_wdata  = m_wdata;
  assign s1_wstrb  = m_wstrb;
  assign s1_araddr = m_araddr;
  assign s1_arprot = m_arprot;

  assign wr_busy = (wstate_q != W_IDLE);
  assign rd_busy = (rstate_q != R_IDLE);

  assign aw_g = (wstate_q == W_ADDR)
              & m_awvalid & ~aw_done_q;
  assign w_g  = (wstate_q == W_ADDR)
              & m_wvalid & ~w_done_q;

  // kept outside the FSM processes to avoid a comb loop
  // through the error responder's ready outputs
  assign e_awvalid = aw_g & (wsel_q == SEL_ERR);
  assign e_wvalid  = w_g & (wsel_q == SEL_ERR);
  assign e_bactive = (wstate_q == W_RESP)
                   & (wsel_q == SEL_ERR);
  assign e_arvalid = (rstate_q == R_ADDR)
                   & (rsel_q == SEL_ERR) & m_arvalid;
  assign e_ractive = (rstate_q == R_DATA)
                   & (rsel_q == SEL_ERR);

  axil_decerr_slave u_err (
    .clk        (clk),
    .reset      (reset),
    .aw_valid_i (e_awvalid),
    .w_valid_i  (e_wvalid),
    .b_active_i (e_bactive),
    .b_ready_i  (m_bready),
    .ar_valid_i (e_arvalid),
    .r_active_i (e_ractive),
    .r_ready_i  (m_rready),
    .aw_ready_o (e_awready),
    .w_ready_o  (e_wready),
    .b_valid_o  (e_bvalid),
    .b_resp_o   (e_bresp),
    .ar_ready_o (e_arready),
    .r_valid_o  (e_rvalid),
    .r_data_o   (e_rdata),
    .r_resp_o   (e_rresp),
    .cnt_o      (decerr_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q  <= W_IDLE;
      wsel_q    <= SEL_SRAM;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rstate_q  <= R_IDLE;
      rsel_q    <= SEL_SRAM;
    end else begin
      wstate_q  <= wstate_d;
      wsel_q    <= wsel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rstate_q  <= rstate_d;
      rsel_q    <= rsel_d;
    end
  end

  always_comb begin
    wstate_d   = wstate_q;
    wsel_d     = wsel_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    s0_awvalid = 1'b0;
    s0_wvalid  = 1'b0;
    s0_bready  = 1'b0;
    s1_awvalid = 1'b0;
    s1_wvalid  = 1'b0;
    s1_bready  = 1'b0;
    m_awready  = 1'b0;
    m_wready   = 1'b0;
    m_bvalid   = 1'b0;
    m_bresp    = RESP_OKAY;
    unique case (wstate_q)
      W_IDLE: begin
        if (m_awvalid) begin
          wsel_d = decode(m_awaddr, SRAM_BASE,
                          SRAM_SIZE, AES_BASE,
                          AES_SIZE);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_ADDR;
        end
      end
      W_ADDR: begin
        unique case (wsel_q)
          SEL_SRAM: begin
            s0_awvalid = aw_g;
            s0_wvalid  = w_g;
            aw_rdy     = s0_awready;
            w_rdy      = s0_wready;
          end
          SEL_AES: begin
            s1_awvalid = aw_g;
            s1_wvalid  = w_g;
            aw_rdy     = s1_awready;
            w_rdy      = s1_wready;
          end
          default: begin
            aw_rdy = e_awready;
            w_rdy  = e_wready;
          end
        endcase
        m_awready = aw_rdy & ~aw_done_q;
        m_wready  = w_rdy & ~w_done_q;
        aw_done_d = aw_done_q
                  | (m_awvalid & m_awready);
        w_done_d  = w_done_q
                  | (m_wvalid & m_wready);
        if (aw_done_d & w_done_d)
          wstate_d = W_RESP;
      end
      W_RESP: begin
        unique case (wsel_q)
          SEL_SRAM: begin
            m_bvalid  = s0_bvalid;
            m_bresp   = s0_bresp;
            s0_bready = m_bready;
          end
          SEL_AES: begin
            m_bvalid  = s1_bvalid;
            m_bresp   = s1_bresp;
            s1_bready = m_bready;
          end
          default: begin
            m_bvalid = e_bvalid;
            m_bresp  = e_bresp;
          end
        endcase
        if (m_bvalid & m_bready)
          wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d   = rstate_q;
    rsel_d     = rsel_q;
    s0_arvalid = 1'b0;
    s0_rready  = 1'b0;
    s1_arvalid = 1'b0;
    s1_rready  = 1'b0;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    m_rresp    = RESP_OKAY;
    unique case (rstate_q)
      R_IDLE: begin
        if (m_arvalid) begin
          rsel_d = decode(m_araddr, SRAM_BASE,
                          SRAM_SIZE, AES_BASE,
                          AES_SIZE);
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        unique case (rsel_q)
          SEL_SRAM: begin
            s0_arvalid = m_arvalid;
            m_arready  = s0_arready;
          end
          SEL_AES: begin
            s1_arvalid = m_arvalid;
            m_arready  = s1_arready;
          end
          default: m_arready = e_arready;
        endcase
        if (m_arvalid & m_arready)
          rstate_d = R_DATA;
      end
      R_DATA: begin
        unique case (rsel_q)
          SEL_SRAM: begin
            m_rvalid  = s0_rvalid;
            m_rdata   = s0_rdata;
            m_rresp   = s0_rresp;
            s0_rready = m_rready;
          end
          SEL_AES: begin
            m_rvalid  = s1_rvalid;
            m_rdata   = s1_rdata;
            m_rresp   = s1_rresp;
            s1_rready = m_rready;
          end
          default: begin
            m_rvalid = e_rvalid;
            m_rdata  = e_rdata;
            m_rresp  = e_rresp;
          end
        endcase
        if (m_rvalid & m_rready)
          rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_bus_decoder.sv
// Directed bench for axil_bus_decoder with two behavioural
// AXI4-Lite memory slaves (s0 = SRAM, s1 = AES).
module tb_axil_bus_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m_awaddr = '0;
  logic [2:0]  m_awprot = '0;
  logic        m_awvalid = 1'b0;
  logic        m_awready;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = 4'hF;
  logic        m_wvalid = 1'b0;
  logic        m_wready;
  logic        m_bvalid;
  logic [1:0]  m_bresp;
  logic        m_bready = 1'b0;
  logic [31:0] m_araddr = '0;
  logic [2:0]  m_arprot = '0;
  logic        m_arvalid = 1'b0;
  logic        m_arready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rready = 1'b0;
  logic        wr_busy, rd_busy;
  logic [7:0]  decerr_cnt;

  logic        sv_awvalid[2], sv_wvalid[2], sv_bready[2];
  logic        sv_arvalid[2], sv_rready[2];
  logic [31:0] sv_awaddr[2], sv_wdata[2], sv_araddr[2];
  logic [2:0]  sv_awprot[2], sv_arprot[2];
  logic [3:0]  sv_wstrb[2];
  logic        sv_awready[2], sv_wready[2], sv_arready[2];
  logic        sv_bvalid[2], sv_rvalid[2];
  logic [1:0]  sv_bresp[2], sv_rresp[2];
  logic [31:0] sv_rdata[2];

  logic [31:0] mem [2][128];
  logic        awg[2], wg[2];
  logic [31:0] awa[2], wdd[2];
  int          ar_cnt[2];
  int          stall_cfg[2] = '{0, 0};
  int          act_aw[2] = '{0, 0};
  int          act_w[2] = '{0, 0};
  int          act_ar[2] = '{0, 0};
  int          act_rdy[2] = '{0, 0};

  int n_vec = 0;
  int n_bad = 0;
  int wr_bwait, wr_busylow, rd_arwait;

  axil_bus_decoder dut (
    .clk(clk), .reset(reset),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp),
    .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rready(m_rready),
    .s0_awaddr(sv_awaddr[0]), .s0_awprot(sv_awprot[0]),
    .s0_awvalid(sv_awvalid[0]), .s0_awready(sv_awready[0]),
    .s0_wdata(sv_wdata[0]), .s0_wstrb(sv_wstrb[0]),
    .s0_wvalid(sv_wvalid[0]), .s0_wready(sv_wready[0]),
    .s0_bvalid(sv_bvalid[0]), .s0_bresp(sv_bresp[0]),
    .s0_bready(sv_bready[0]),
    .s0_araddr(sv_araddr[0]), .s0_arprot(sv_arprot[0]),
    .s0_arvalid(sv_arvalid[0]), .s0_arready(sv_arready[0]),
    .s0_rvalid(sv_rvalid[0]), .s0_rdata(sv_rdata[0]),
    .s0_rresp(sv_rresp[0]), .s0_rready(sv_rready[0]),
    .s1_awaddr(sv_awaddr[1]), .s1_awprot(sv_awprot[1]),
    .s1_awvalid(sv_awvalid[1]), .s1_awready(sv_awready[1]),
    .s1_wdata(sv_wdata[1]), .s1_wstrb(sv_wstrb[1]),
    .s1_wvalid(sv_wvalid[1]), .s1_wready(sv_wready[1]),
    .s1_bvalid(sv_bvalid[1]), .s1_bresp(sv_bresp[1]),
    .s1_bready(sv_bready[1]),
    .s1_araddr(sv_araddr[1]), .s1_arprot(sv_arprot[1]),
    .s1_arvalid(sv_arvalid[1]), .s1_arready(sv_arready[1]),
    .s1_rvalid(sv_rvalid[1]), .s1_rdata(sv_rdata[1]),
    .s1_rresp(sv_rresp[1]), .s1_rready(sv_rready[1]),
    .wr_busy(wr_busy), .rd_busy(rd_busy),
    .decerr_cnt(decerr_cnt)
  );

  // slave models: AW/W always ready, AR stalls stall_cfg cycles
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sv_awready[i] = 1'b1;
      sv_wready[i]  = 1'b1;
      sv_bresp[i]   = 2'b00;
      sv_rresp[i]   = 2'b00;
      sv_arready[i] = (ar_cnt[i] >= stall_cfg[i]);
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sv_bvalid[i] <= 1'b0;
        sv_rvalid[i] <= 1'b0;
        sv_rdata[i]  <= '0;
        awg[i]       <= 1'b0;
        wg[i]        <= 1'b0;
        ar_cnt[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sv_awvalid[i] && sv_awready[i]) begin
          awg[i] <= 1'b1;
          awa[i] <= sv_awaddr[i];
        end
        if (sv_wvalid[i] && sv_wready[i]) begin
          wg[i]  <= 1'b1;
          wdd[i] <= sv_wdata[i];
        end
        if (awg[i] && wg[i] && !sv_bvalid[i]) begin
          mem[i][awa[i][8:2]] <= wdd[i];
          sv_bvalid[i] <= 1'b1;
          awg[i] <= 1'b0;
          wg[i]  <= 1'b0;
        end
        if (sv_bvalid[i] && sv_bready[i])
          sv_bvalid[i] <= 1'b0;
        if (sv_arvalid[i] && sv_arready[i]) begin
          sv_rvalid[i] <= 1'b1;
          sv_rdata[i]  <= mem[i][sv_araddr[i][8:2]];
          ar_cnt[i]    <= 0;
        end else if (sv_arvalid[i]) begin
          ar_cnt[i] <= ar_cnt[i] + 1;
        end
        if (sv_rvalid[i] && sv_rready[i])
          sv_rvalid[i] <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sv_awvalid[i]) act_aw[i] <= act_aw[i] + 1;
      if (sv_wvalid[i])  act_w[i]  <= act_w[i] + 1;
      if (sv_arvalid[i]) act_ar[i] <= act_ar[i] + 1;
      if (sv_bready[i] || sv_rready[i])
        act_rdy[i] <= act_rdy[i] + 1;
    end
  end

  function automatic int act_all();
    return act_aw[0] + act_aw[1] + act_w[0] + act_w[1]
         + act_ar[0] + act_ar[1]
         + act_rdy[0] + act_rdy[1];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input int aw_dly,
                          input int w_dly,
                          input int b_hold,
                          output logic [1:0] resp);
    int cyc;
    int bv;
    bit awd, wd, bd;
    cyc = 0; bv = 0; awd = 0; wd = 0; bd = 0;
    resp = 2'bxx;
    wr_busylow = 0;
    while (!bd && cyc < 60) begin
      @(negedge clk);
      m_awaddr  = a;
      m_wdata   = d;
      m_wstrb   = 4'hF;
      m_awvalid = !awd && (cyc >= aw_dly);
      m_wvalid  = !wd && (cyc >= w_dly);
      m_bready  = (bv >= b_hold);
      #1;
      if (cyc > aw_dly && !wr_busy) wr_busylow++;
      if (m_awvalid && m_awready) awd = 1;
      if (m_wvalid && m_wready) wd = 1;
      if (m_bvalid && !m_bready) bv++;
      if (m_bvalid && m_bready) begin
        bd = 1;
        resp = m_bresp;
      end
      cyc++;
    end
    wr_bwait = bv;
    @(negedge clk);
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    chk("wr_complete", 32'(bd), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a,
                         output logic [31:0] data,
                         output logic [1:0] resp);
    int cyc;
    bit ard, rd;
    cyc = 0; ard = 0; rd = 0;
    data = 'x;
    resp = 2'bxx;
    rd_arwait = 0;
    while (!rd && cyc < 60) begin
      @(negedge clk);
      m_araddr  = a;
      m_arvalid = !ard;
      m_rready  = 1'b1;
      #1;
      if (rd_busy && m_arvalid && !m_arready)
        rd_arwait++;
      if (m_arvalid && m_arready) ard = 1;
      if (m_rvalid && m_rready) begin
        rd = 1;
        data = m_rdata;
        resp = m_rresp;
      end
      cyc++;
    end
    @(negedge clk);
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    chk("rd_complete", 32'(rd), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  wresp, rresp;
    logic [31:0] rdat;
    logic [31:0] bad_a[3];
    int snap0, snap1, snap2;
    bit seen;

    bad_a[0] = 32'h0000_0200;
    bad_a[1] = 32'h0000_02FF;
    bad_a[2] = 32'h0000_0400;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", {30'd0, wr_busy, rd_busy}, 32'd0);
    chk("rst_decerr", {24'd0, decerr_cnt}, 32'd0);
    chk("rst_m_hs", {26'd0, m_awready, m_wready,
        m_bvalid, m_arready, m_rvalid, m_bresp != 0},
        32'd0);
    chk("rst_rdata", m_rdata, 32'd0);

    // SRAM top word, AW and W together
    snap0 = act_aw[1] + act_w[1];
    snap1 = act_aw[0];
    snap2 = act_w[0];
    do_write(32'h1FC, 32'hDEADBEEF, 0, 0, 0, wresp);
    chk("sram_wr_bresp", 32'(wresp), 32'd0);
    chk("sram_wr_s1_quiet", 32'(act_aw[1] + act_w[1]
        - snap0), 32'd0);
    chk("sram_wr_s0_aw", 32'(act_aw[0] - snap1), 32'd1);
    chk("sram_wr_s0_w", 32'(act_w[0] - snap2), 32'd1);
    chk("sram_mem", mem[0][127], 32'hDEADBEEF);
    do_read(32'h1FC, rdat, rresp);
    chk("sram_rd_data", rdat, 32'hDEADBEEF);
    chk("sram_rd_resp", 32'(rresp), 32'd0);

    // AES writes, then stalled AES read
    do_write(32'h300, 32'h1111_1111, 0, 0, 0, wresp);
    chk("aes_wr300_bresp", 32'(wresp), 32'd0);
    do_write(32'h30C, 32'hCAFE_0030, 0, 0, 0, wresp);
    chk("aes_wr30c_bresp", 32'(wresp), 32'd0);
    chk("aes_mem300", mem[1][7'h40], 32'h1111_1111);
    stall_cfg[1] = 3;
    snap0 = act_ar[0];
    do_read(32'h30C, rdat, rresp);
    stall_cfg[1] = 0;
    chk("aes_rd_data", rdat, 32'hCAFE_0030);
    chk("aes_rd_resp", 32'(rresp), 32'd0);
    chk("aes_rd_arwait", 32'(rd_arwait), 32'd3);
    chk("aes_rd_s0_quiet", 32'(act_ar[0] - snap0), 32'd0);

    // unmapped boundaries answered internally
    snap0 = act_all();
    for (int k = 0; k < 3; k++) begin
      do_write(bad_a[k], 32'h5555_AAAA, 0, 0, 0, wresp);
      chk("err_bresp", 32'(wresp), 32'd3);
      do_read(bad_a[k], rdat, rresp);
      chk("err_rresp", 32'(rresp), 32'd3);
      chk("err_rdata", rdat, 32'd0);
    end
    chk("err_no_slave", 32'(act_all() - snap0), 32'd0);
    chk("err_cnt6", {24'd0, decerr_cnt}, 32'd6);
    do_read(32'h1FF, rdat, rresp);
    chk("edge_1ff_resp", 32'(rresp), 32'd0);
    chk("edge_1ff_data", rdat, 32'hDEADBEEF);
    snap0 = act_ar[1];
    do_read(32'h3FF, rdat, rresp);
    chk("edge_3ff_resp", 32'(rresp), 32'd0);
    chk("edge_3ff_s1", 32'(act_ar[1] - snap0), 32'd1);
    chk("edge_cnt_kept", {24'd0, decerr_cnt}, 32'd6);

    // W two cycles ahead of AW, B held off four cycles
    do_write(32'h010, 32'h1234_5678, 2, 0, 4, wresp);
    chk("late_aw_bresp", 32'(wresp), 32'd0);
    chk("late_aw_bwait", 32'(wr_bwait), 32'd4);
    chk("late_aw_busy", 32'(wr_busylow), 32'd0);
    do_read(32'h010, rdat, rresp);
    chk("late_aw_rd", rdat, 32'h1234_5678);

    // overlapped SRAM read and AES write
    snap0 = act_aw[0] + act_w[0];
    snap1 = act_ar[1];
    fork
      do_write(32'h304, 32'hAE5A_E5AE, 1, 0, 2, wresp);
      do_read(32'h1FC, rdat, rresp);
    join
    chk("ovl_bresp", 32'(wresp), 32'd0);
    chk("ovl_rresp", 32'(rresp), 32'd0);
    chk("ovl_rdata", rdat, 32'hDEADBEEF);
    chk("ovl_s0_no_wr", 32'(act_aw[0] + act_w[0]
        - snap0), 32'd0);
    chk("ovl_s1_no_rd", 32'(act_ar[1] - snap1), 32'd0);
    do_read(32'h304, rdat, rresp);
    chk("ovl_aes_mem", rdat, 32'hAE5A_E5AE);

    // reset while parked in W_RESP
    seen = 0;
    @(negedge clk);
    m_awaddr  = 32'h020;
    m_wdata   = 32'h0000_0077;
    m_awvalid = 1'b1;
    m_wvalid  = 1'b1;
    m_bready  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (m_bvalid) seen = 1;
    end
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    chk("rstmid_bvalid_up", 32'(seen), 32'd1);
    chk("rstmid_busy_up", 32'(wr_busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_async", {29'd0, m_bvalid, wr_busy,
        decerr_cnt != 0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid_outs", {22'd0, m_bvalid, m_awready,
        m_wready, m_arready, m_rvalid, wr_busy, rd_busy,
        sv_bready[0], sv_awvalid[0], sv_wvalid[0]},
        32'd0);
    chk("rstmid_cnt", {24'd0, decerr_cnt}, 32'd0);
    do_write(32'h020, 32'h0BAD_F00D, 0, 0, 0, wresp);
    chk("rstmid_new_bresp", 32'(wresp), 32'd0);
    do_read(32'h020, rdat, rresp);
    chk("rstmid_new_rd", rdat, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
